// File: rtl/iftest_mon_pkg.sv
// iftest_mon_pkg: shared widths and record type for the iftest state monitor.
// Record carries a timestamp only when IFTEST_MON_TIMESTAMP_EN is defined.
package iftest_mon_pkg;
    localparam int STATE_W = 3;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIME_W  = 16;

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [ADDR_W-1:0]  address;
        logic [DATA_W-1:0]  data;
        logic               seq_err;
`ifdef IFTEST_MON_TIMESTAMP_EN
        logic [TIME_W-1:0]  ts;
`endif
    } mon_rec_t;
endpackage

// File: rtl/iftest_mon_fifo.sv
// iftest_mon_fifo: synchronous FIFO of monitor records; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module iftest_mon_fifo
    import iftest_mon_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  mon_rec_t               din,
    output mon_rec_t               dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    mon_rec_t      mem_q [DEPTH];

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == (AW+1)'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        level   = cnt_q;
        dout    = mem_q[rd_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/iftest_state_monitor.sv
// iftest_state_monitor: logs every iftest state change into a drainable FIFO.
// Define IFTEST_MON_TIMESTAMP_EN to stamp records with a 16-bit cycle count.
module iftest_state_monitor
    import iftest_mon_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int WRAP_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             in_state,
    input  logic [7:0]             in_address,
    input  logic [7:0]             in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_state,
    output logic [7:0]             out_address,
    output logic [7:0]             out_data,
    output logic                   out_seq_err,
`ifdef IFTEST_MON_TIMESTAMP_EN
    output logic [15:0]            out_time,
`endif
    output logic [$clog2(DEPTH):0] level,
    output logic [WRAP_W-1:0]      wrap_count,
    output logic                   overflow
);
    mon_rec_t           rec, head;
    logic               push, pop, full, empty;
    logic [STATE_W-1:0] prev_q, prev_d, step;
    logic               primed_q, primed_d, overflow_q, overflow_d;
    logic [WRAP_W-1:0]  wrap_q, wrap_d;
`ifdef IFTEST_MON_TIMESTAMP_EN
    logic [TIME_W-1:0]  time_q, time_d;
`endif

    always_comb begin
        out_valid   = !empty;
        pop         = out_valid && out_ready;
        step        = prev_q + STATE_W'(1);
        push        = primed_q && (in_state != prev_q);
        rec         = '0;
        rec.state   = in_state;
        rec.address = in_address;
        rec.data    = in_data;
        rec.seq_err = (in_state != step);
`ifdef IFTEST_MON_TIMESTAMP_EN
        rec.ts      = time_q;
        time_d      = time_q + TIME_W'(1);
`endif
        prev_d      = in_state;
        primed_d    = 1'b1;
        wrap_d      = (push && prev_q == '1 && in_state == '0 && wrap_q != '1) ? wrap_q + WRAP_W'(1) : wrap_q;
        // a pop in the same cycle frees the slot, so only an unpopped full FIFO drops
        overflow_d  = overflow_q | (push && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            primed_q   <= 1'b0;
            wrap_q     <= '0;
            overflow_q <= 1'b0;
`ifdef IFTEST_MON_TIMESTAMP_EN
            time_q     <= '0;
`endif
        end else begin
            prev_q     <= prev_d;
            primed_q   <= primed_d;
            wrap_q     <= wrap_d;
            overflow_q <= overflow_d;
`ifdef IFTEST_MON_TIMESTAMP_EN
            time_q     <= time_d;
`endif
        end
    end

    iftest_mon_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rec),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign out_state   = out_valid ? head.state : '0;
    assign out_address = out_valid ? head.address : '0;
    assign out_data    = out_valid ? head.data : '0;
    assign out_seq_err = out_valid && head.seq_err;
`ifdef IFTEST_MON_TIMESTAMP_EN
    assign out_time    = out_valid ? head.ts : '0;
`endif
    assign wrap_count  = wrap_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_iftest_state_monitor.sv
// tb_iftest_state_monitor: directed bench for iftest_state_monitor (default build).
module tb_iftest_state_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in_state = '0;
    logic [7:0]  in_address = '0;
    logic [7:0]  in_data = '0;
    logic        out_ready = 1'b1;
    logic        out_valid, out_seq_err, overflow;
    logic [2:0]  out_state;
    logic [7:0]  out_address, out_data;
    logic [3:0]  level;
    logic [15:0] wrap_count;
    int          total = 0;
    int          bad = 0;

    iftest_state_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .in_state    (in_state),
        .in_address  (in_address),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_state   (out_state),
        .out_address (out_address),
        .out_data    (out_data),
        .out_seq_err (out_seq_err),
        .level       (level),
        .wrap_count  (wrap_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input logic [2:0] s);
        return {s, s, s[1:0]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] data_of(input logic [2:0] s);
        return 8'hC3 + {5'd0, s};
    endfunction

    task automatic drive(input logic [2:0] s);
        in_state   = s;
        in_address = addr_of(s);
        in_data    = data_of(s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // head compared as one packed value: {valid, state, address, data, seq_err}
    task automatic chk_head(input string tag, input logic [2:0] s, input logic e);
        chk(tag, {11'd0, out_valid, out_state, out_address, out_data, out_seq_err},
            {11'd0, 1'b1, s, addr_of(s), data_of(s), e});
    endtask

    initial begin
        drive(3'd0);
        tick();
        tick();
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_wrap", wrap_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_fields", {out_state, out_address, out_data, out_seq_err}, 0);
        rst = 1'b0;
        tick();
        chk("prime_level", level, 0);

        for (int i = 1; i <= 8; i++) begin
            drive(3'(i));
            tick();
            chk_head("t1_head", 3'(i), 1'b0);
            chk("t1_level", level, 1);
        end
        chk("t1_wrap", wrap_count, 1);
        tick();
        chk("t1_drain", level, 0);
        chk("t1_ovf", overflow, 0);

        drive(3'd3);
        tick();
        chk_head("t2_jump3", 3'd3, 1'b1);
        repeat (5) tick();
        chk("t2_hold_level", level, 0);
        chk("t2_hold_valid", out_valid, 0);
        drive(3'd5);
        tick();
        chk_head("t2_jump5", 3'd5, 1'b1);
        chk("t2_level", level, 1);
        tick();
        chk("t2_drain", level, 0);

        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(3'(6 + i));
            tick();
            if (i == 7) begin
                chk("t3_full_level", level, 8);
                chk("t3_full_noovf", overflow, 0);
            end
        end
        chk("t3_level", level, 8);
        chk("t3_ovf", overflow, 1);
        chk("t3_wrap", wrap_count, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_head("t3_pop", 3'(6 + i), 1'b0);
            tick();
        end
        chk("t3_empty", level, 0);
        chk("t3_ovf_sticky", overflow, 1);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'(i));
            tick();
        end
        chk("t5_level4", level, 4);
        chk("t5_wrap3", wrap_count, 3);
        rst = 1'b1;
        drive(3'd5);
        tick();
        chk("t5_level", level, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_wrap", wrap_count, 0);
        chk("t5_ovf", overflow, 0);
        rst = 1'b0;
        drive(3'd6);
        tick();
        chk("t5_no_push", level, 0);

        for (int i = 0; i < 8; i++) begin
            drive(3'(7 + i));
            tick();
        end
        chk("t4_full", level, 8);
        chk("t4_noovf_pre", overflow, 0);
        out_ready = 1'b1;
        drive(3'd7);
        tick();
        chk("t4_level", level, 8);
        chk("t4_noovf", overflow, 0);
        for (int i = 0; i < 8; i++) begin
            chk_head("t4_pop", 3'(i), 1'b0);
            tick();
        end
        chk("t4_empty", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iftest_state_monitor.md
Name: iftest_state_monitor

Overview:
- Downstream consumer of the state-stepping producer on the iftest bus.
- Watches the 3-bit state plus the address/data wires every clk.
- On each state change, logs a record (state, address, data, sequence-error flag) into a small FIFO.
- The FIFO drains over a valid/ready handshake; the block also keeps a wrap counter and a sticky overflow flag for the bench and scoreboard.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- WRAP_W, 16, width of the wrap counter.

Ports:
- clk  input  1  bus clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_state  input  3  producer state.
- in_address  input  8  bus address.
- in_data  input  8  bus data.
- out_valid  output  1  FIFO head holds a record.
- out_ready  input  1  consumer accepts head.
- out_state  output  3  head record state.
- out_address  output  8  head record address.
- out_data  output  8  head record data.
- out_seq_err  output  1  head record was a non-+1 step.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- wrap_count  output  WRAP_W  count of 7->0 steps, saturating.
- overflow  output  1  sticky: a record was dropped.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, level=0, wrap_count=0, overflow=0, primed=0, all out_* record fields=0.
- Priming:
  - First cycle after reset deasserts: prev_state <= in_state, primed <= 1, no record pushed.
- Change detection (primed=1):
  - If in_state != prev_state, push record {in_state, in_address, in_data, seq_err}.
  - seq_err = (in_state != prev_state+1 mod 8).
  - prev_state <= in_state.
  - No push when the state is unchanged.
- Wrap: prev_state==7 && in_state==0 -> wrap_count++, holding at all-ones.
  - 7->0 is a legal step: seq_err=0.
- Latency: state change sampled at edge N -> out_valid=1 with that record after edge N (registered; visible in cycle N+1).
- FIFO rules:
  - out_valid = (level != 0); out_* reflect the head.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle: level unchanged; both complete.
  - Full, push, no pop: record dropped, overflow <= 1, stays set until rst.
  - Full, push, and pop in the same cycle: push accepted, no overflow.
  - Empty with out_ready=1: no pop, level stays 0.
  - Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- Reset mid-operation:
  - FIFO flushed, primed cleared, counters and flag cleared on the reset edge.
  - in_state present during reset is never logged.

Optional Feature:
- Macro IFTEST_MON_TIMESTAMP_EN.
- Defined:
  - 16-bit free-running cycle counter, cleared by rst, wraps.
  - Value is captured into each record.
  - Extra output port out_time[15:0] carries the head record's timestamp (0 at reset).
- Undefined: no counter, no out_time port; record width unchanged from the base definition.

Decomposition:
- Package iftest_mon_pkg:
  - STATE_W=3, ADDR_W=8, DATA_W=8, TIME_W=16.
  - Packed struct mon_rec_t {state, address, data, seq_err[, time under macro]}.
- Sub-module iftest_mon_fifo: synchronous FIFO of mon_rec_t, parameterised DEPTH.
  - Ports: push, pop, full, empty, level.
  - Overflow detection stays in the top.

Test Plan:
1. Reset, then in_state steps 0..7,0 every cycle with out_ready=1 -> 8 records after priming, states 1..7,0, seq_err=0 throughout, wrap_count=1, overflow=0.
2. in_state held 3 for 5 cycles, then 3->5 -> exactly one record: state=5, seq_err=1.
3. out_ready=0, 10 distinct steps -> level=8, overflow=1, first 8 records retained in order. Then out_ready=1 -> 8 pops, level=0, overflow still 1.
4. FIFO full, one step with out_ready=1 in the same cycle -> level stays 8, overflow=0, new record at tail.
5. rst asserted while level=4 -> next cycle level=0, out_valid=0, wrap_count=0. First post-reset cycle does not push.
6. With IFTEST_MON_TIMESTAMP_EN, steps at cycles 3 and 7 after reset release -> out_time values differ by 4.
